// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: func3 load/store size codes and data-memory FSM states.
// Also used by the control unit; keep encodings stable.
package riscv_pkg;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    function automatic logic size_legal(input logic we, input logic [2:0] size);
        if (we) begin
            return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W);
        end
        return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W) ||
               (size == SIZE_BU) || (size == SIZE_HU);
    endfunction

    function automatic logic misaligned(input logic [1:0] offset, input logic [2:0] size);
        case (size)
            SIZE_H, SIZE_HU: return offset[0];
            SIZE_W:          return offset != 2'b00;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_load_extender.sv
// Combinational lane extraction and sign/zero extension of a 32-bit memory word
// for RISC-V LB/LH/LW/LBU/LHU.
module load_extender
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  size,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr[1] ? word[31:16] : word[15:0];

        case (size)
            SIZE_B:  result = {{24{byte_lane[7]}}, byte_lane};
            SIZE_H:  result = {{16{half_lane[15]}}, half_lane};
            SIZE_W:  result = word;
            SIZE_BU: result = {24'd0, byte_lane};
            SIZE_HU: result = {16'd0, half_lane};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with valid/ready request and response channels.
// Optional wait states enabled by defining DMEM_WAIT_STATE_EN.
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    mem_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

`ifdef DMEM_WAIT_STATE_EN
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    logic             cur_we;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [2:0]       cur_size;
    logic             cur_err;
    logic [IDX_W-1:0] cur_idx;
    logic             enter_resp;
    logic [31:0]      rd_word;
    logic [31:0]      ld_result;
    logic [31:0]      wr_data;
    logic [3:0]       wr_mask;

    // Without wait states RESP is entered on the accept edge itself, so the
    // transaction is taken from the live request rather than the capture regs.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_size  = req_size;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_size  = size_q;
        end
        cur_idx = cur_addr[IDX_W+1:2];
        cur_err = !size_legal(cur_we, cur_size) ||
                  misaligned(cur_addr[1:0], cur_size) ||
                  (cur_addr[31:2] >= 30'(DEPTH_WORDS));
    end

    assign rd_word = mem[cur_idx];

    load_extender u_load_extender (
        .word   (rd_word),
        .addr   (cur_addr[1:0]),
        .size   (cur_size),
        .result (ld_result)
    );

    always_comb begin
        case (cur_size)
            SIZE_B: begin
                wr_data = {4{cur_wdata[7:0]}};
                wr_mask = 4'b0001 << cur_addr[1:0];
            end
            SIZE_H: begin
                wr_data = {2{cur_wdata[15:0]}};
                wr_mask = cur_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = cur_wdata;
                wr_mask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
`ifdef DMEM_WAIT_STATE_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
`ifdef DMEM_WAIT_STATE_EN
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
`else
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
`endif
                end
            end
            ST_WAIT: begin
`ifdef DMEM_WAIT_STATE_EN
                if (cnt_q == CNT_W'(WAIT_STATES - 1)) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_err || cur_we) ? '0 : ld_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_WAIT_STATE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Storage is never cleared by reset; a store commits on the RESP entry edge.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && cur_we && !cur_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[cur_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus random traffic
// against a byte-level memory model. Latency expectation follows DMEM_WAIT_STATE_EN.
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int WS    = 2;
`ifdef DMEM_WAIT_STATE_EN
    localparam int LAT     = WS + 1;
    localparam bit WAIT_EN = 1'b1;
`else
    localparam int LAT     = 1;
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [DEPTH];

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned access_bytes(input logic [2:0] s);
        if (s == 3'd0 || s == 3'd4) return 1;
        if (s == 3'd1 || s == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit exp_err(input bit we, input logic [31:0] a, input logic [2:0] s);
        bit legal;
        legal = we ? (s <= 3'd2) : (s <= 3'd2 || s == 3'd4 || s == 3'd5);
        if (!legal) return 1'b1;
        if (a % access_bytes(s) != 0) return 1'b1;
        if (a / 4 >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] s);
        logic [31:0] v;
        v = model[a / 4] >> (8 * (a % 4));
        case (s)
            3'd0: begin v = v & 32'hFF;   return (v >= 128)   ? v + 32'hFFFFFF00 : v; end
            3'd1: begin v = v & 32'hFFFF; return (v >= 32768) ? v + 32'hFFFF0000 : v; end
            3'd4: return v & 32'hFF;
            3'd5: return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] s);
        logic [31:0] w;
        int unsigned lane;
        w = model[a / 4];
        for (int unsigned k = 0; k < access_bytes(s); k++) begin
            lane = a % 4 + k;
            w = (w & ~(32'hFF << (8 * lane))) | (((wd >> (8 * k)) & 32'hFF) << (8 * lane));
        end
        model[a / 4] = w;
    endfunction

    task automatic xact(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] s, input int hold,
                        output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        bit          eerr;
        int          lat;
        eerr = exp_err(we, a, s);
        erd  = (eerr || we) ? 32'h0 : exp_load(a, s);

        @(negedge clk);
        check({tag, "/req_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_size  = s;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;

        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(LAT));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            check({tag, "/hold_rdata"}, rsp_rdata, erd);
            check({tag, "/hold_req_ready"}, {31'd0, req_ready}, 32'd0);
        end

        rd = rsp_rdata;
        er = rsp_err;
        check({tag, "/rdata"}, rsp_rdata, erd);
        check({tag, "/err"}, {31'd0, rsp_err}, {31'd0, eerr});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "/idle_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "/idle_rdata"}, rsp_rdata, 32'd0);
        check({tag, "/idle_err"}, {31'd0, rsp_err}, 32'd0);

        if (we && !eerr) model_store(a, wd, s);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        logic [2:0]  s;
        logic        we;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset/req_ready", {31'd0, req_ready}, 32'd1);
        check("reset/rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset/rsp_rdata", rsp_rdata, 32'd0);
        check("reset/rsp_err", {31'd0, rsp_err}, 32'd0);

        // Give every word a known value so loads are fully defined.
        for (int i = 0; i < DEPTH; i++) begin
            xact("fill", 1'b1, 32'(i * 4), $urandom, 3'd2, 0, rd, er);
        end

        xact("sw_0x10", 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, rd, er);
        check("sw_0x10/rdata_zero", rd, 32'h0);
        xact("lw_0x10", 1'b0, 32'h10, 32'h0, 3'd2, 0, rd, er);
        check("lw_0x10/value", rd, 32'hDEADBEEF);
        check("lw_0x10/err", {31'd0, er}, 32'd0);
        xact("lb_0x13", 1'b0, 32'h13, 32'h0, 3'd0, 0, rd, er);
        check("lb_0x13/value", rd, 32'hFFFFFFDE);
        xact("lbu_0x13", 1'b0, 32'h13, 32'h0, 3'd4, 0, rd, er);
        check("lbu_0x13/value", rd, 32'h000000DE);
        xact("lh_0x12", 1'b0, 32'h12, 32'h0, 3'd1, 0, rd, er);
        check("lh_0x12/value", rd, 32'hFFFFDEAD);
        xact("lhu_0x10", 1'b0, 32'h10, 32'h0, 3'd5, 0, rd, er);
        check("lhu_0x10/value", rd, 32'h0000BEEF);
        xact("sb_0x11", 1'b1, 32'h11, 32'h55, 3'd0, 0, rd, er);
        xact("lw_after_sb", 1'b0, 32'h10, 32'h0, 3'd2, 0, rd, er);
        check("lw_after_sb/value", rd, 32'hDEAD55EF);

        xact("lw_0x12_misal", 1'b0, 32'h12, 32'h0, 3'd2, 0, rd, er);
        check("lw_0x12_misal/err", {31'd0, er}, 32'd1);
        xact("sh_0x11_misal", 1'b1, 32'h11, 32'hFFFF, 3'd1, 0, rd, er);
        check("sh_0x11_misal/err", {31'd0, er}, 32'd1);
        xact("lw_oob", 1'b0, 32'(DEPTH * 4), 32'h0, 3'd2, 0, rd, er);
        check("lw_oob/err", {31'd0, er}, 32'd1);
        xact("sw_illegal_size", 1'b1, 32'h10, 32'h0, 3'd4, 0, rd, er);
        xact("lw_unchanged", 1'b0, 32'h10, 32'h0, 3'd2, 4, rd, er);
        check("lw_unchanged/value", rd, 32'hDEAD55EF);

        // Reset one cycle after accepting a store: in WAIT it aborts, in RESP it is already written.
        @(negedge clk);
        check("rst_sw/req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_size  = 3'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_sw/rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_sw/req_ready_after", {31'd0, req_ready}, 32'd1);
        check("rst_sw/rsp_rdata", rsp_rdata, 32'd0);
        if (!WAIT_EN) model_store(32'h20, 32'h12345678, 3'd2);
        xact("rst_sw/lw_0x20", 1'b0, 32'h20, 32'h0, 3'd2, 0, rd, er);

        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            s  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a = 32'(DEPTH * 4) + $urandom_range(0, 15);
                1:       a = $urandom;
                default: a = $urandom_range(0, DEPTH * 4 - 1);
            endcase
            xact("random", we, a, $urandom, s, int'($urandom_range(0, 2)), rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
